// File: rtl/ledstrip_col_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : ledstrip_col_scanner_if
// Brief    : Bundles the char-code handshake, char ROM port and column
//            stream handshake of the ledstrip column scanner.
// Revision : 1.0  initial release
// ============================================================================
interface ledstrip_col_scanner_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int COL_W      = 7,
  parameter int GLYPH_W    = 35
);
  logic [ADDR_WIDTH-1:0] char_code;
  logic                  char_valid;
  logic                  char_ready;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [GLYPH_W-1:0]    rom_data;
  logic [COL_W-1:0]      col_data;
  logic                  col_valid;
  logic                  col_ready;
  logic                  col_last;

  // Environment side: supplies chars, ROM data and downstream ready
  modport master (
    output char_code, char_valid, rom_data, col_ready,
    input  char_ready, rom_addr, col_data, col_valid, col_last
  );

  // Scanner side
  modport slave (
    input  char_code, char_valid, rom_data, col_ready,
    output char_ready, rom_addr, col_data, col_valid, col_last
  );
endinterface
`default_nettype wire

// File: rtl/ledstrip_col_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ledstrip_col_scanner
// Brief    : Accepts a char code, fetches its 5x7 glyph from the char ROM and
//            streams it out column by column followed by blank gap columns.
//            Optional macro LEDSTRIP_PROP_FONT_EN enables proportional
//            spacing (only the non-blank column range of each glyph is sent).
// Revision : 1.0  initial release
// ============================================================================
module ledstrip_col_scanner #(
  parameter int ADDR_WIDTH = 7,
  parameter int COL_W      = 7,
  parameter int GLYPH_COLS = 5,
  parameter int GAP_COLS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  ledstrip_col_scanner_if.slave bus,
  output logic                  busy
);

  localparam int c_GLYPH_W = COL_W * GLYPH_COLS;
  localparam int c_TOTAL   = GLYPH_COLS + GAP_COLS;
  localparam int c_IDX_W   = $clog2(c_TOTAL + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_EMIT  = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [c_GLYPH_W-1:0]  r_glyph;
  logic [c_IDX_W-1:0]    r_col_idx;
  logic [c_IDX_W-1:0]    r_end_idx;
  logic [COL_W-1:0]      r_col_data;
  logic                  r_col_valid;
  logic                  r_col_last;

  logic [c_IDX_W-1:0]    w_first_idx;
  logic [c_IDX_W-1:0]    w_last_glyph;
  logic [c_IDX_W-1:0]    w_load_idx;

  // Column c of a glyph, column 0 in the top bits; indexes past the glyph are gap columns
  function automatic logic [COL_W-1:0] col_of(input logic [c_GLYPH_W-1:0] g,
                                              input logic [c_IDX_W-1:0]   c);
    logic [c_GLYPH_W-1:0] sh;
    sh = g << (COL_W * int'(c));
    if (c < c_IDX_W'(GLYPH_COLS)) return sh[c_GLYPH_W-1 -: COL_W];
    else                          return '0;
  endfunction

`ifdef LEDSTRIP_PROP_FONT_EN
  logic w_found;

  // Locate first/last non-blank column of the glyph arriving from the ROM; blank glyph spans 0..1
  always_comb begin
    w_found      = 1'b0;
    w_first_idx  = '0;
    w_last_glyph = c_IDX_W'(1);
    for (int c = 0; c < GLYPH_COLS; c++) begin
      if (|bus.rom_data[c_GLYPH_W-1-COL_W*c -: COL_W]) begin
        if (!w_found) w_first_idx = c_IDX_W'(c);
        w_last_glyph = c_IDX_W'(c);
        w_found      = 1'b1;
      end
    end
  end
`else
  // Fixed pitch: every glyph column is sent
  assign w_first_idx  = '0;
  assign w_last_glyph = c_IDX_W'(GLYPH_COLS - 1);
`endif

  // Column to present next: same index while priming, else the following one
  assign w_load_idx = r_col_valid ? r_col_idx + c_IDX_W'(1) : r_col_idx;

  // Main FSM with registered column output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_rom_addr  <= '0;
      r_glyph     <= '0;
      r_col_idx   <= '0;
      r_end_idx   <= '0;
      r_col_data  <= '0;
      r_col_valid <= 1'b0;
      r_col_last  <= 1'b0;
    end else if (flush) begin
      r_state     <= c_IDLE;
      r_col_valid <= 1'b0;
      r_col_last  <= 1'b0;
      r_col_idx   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.char_valid) begin
            r_rom_addr <= bus.char_code;
            r_state    <= c_FETCH;
          end
        end
        c_FETCH: begin
          r_glyph   <= bus.rom_data;
          r_col_idx <= w_first_idx;
          r_end_idx <= w_last_glyph + c_IDX_W'(GAP_COLS);
          r_state   <= c_EMIT;
        end
        c_EMIT: begin
          if (r_col_valid && bus.col_ready && r_col_last) begin
            r_state     <= c_IDLE;
            r_col_valid <= 1'b0;
            r_col_last  <= 1'b0;
            r_col_data  <= '0;
            r_col_idx   <= '0;
          end else if (!r_col_valid || bus.col_ready) begin
            r_col_idx   <= w_load_idx;
            r_col_data  <= col_of(r_glyph, w_load_idx);
            r_col_last  <= (w_load_idx == r_end_idx);
            r_col_valid <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.char_ready = (r_state == c_IDLE) && !flush;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.col_data   = r_col_data;
  assign bus.col_valid  = r_col_valid;
  assign bus.col_last   = r_col_last;
  assign busy           = (r_state != c_IDLE);

endmodule
`default_nettype wire
